// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the SammingCPU fetch front end.
// Holds the address/instruction types, the IF/ID bundle and alignment helper.
package inst_fetch_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_addr_t RESET_VECTOR = 32'h0000_0000;
    localparam inst_addr_t PC_INC       = 32'd4;
    localparam inst_t      ZERO_WORD    = 32'h0000_0000;
    localparam inst_t      NOP_INST     = ZERO_WORD;
    localparam logic       CHIP_ENABLE  = 1'b1;
    localparam logic       CHIP_DISABLE = 1'b0;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
        logic       valid;
        logic       addr_err;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:       ZERO_WORD,
        inst:     NOP_INST,
        valid:    1'b0,
        addr_err: 1'b0
    };

    function automatic logic misaligned(inst_addr_t a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction ROM bus between fetch (master) and ROM (slave).
// Ports: rom_ce/rom_addr from fetch, rom_inst combinational return from ROM.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic       rom_ce;
    inst_addr_t rom_addr;
    inst_t      rom_inst;

    modport master (
        output rom_ce,
        output rom_addr,
        input  rom_inst
    );

    modport slave (
        input  rom_ce,
        input  rom_addr,
        output rom_inst
    );

endinterface

// File: rtl/inst_fetch_if_id.sv
// if_id: IF/ID pipeline register with bubble, load and hold controls.
// Ports: clk, rst (async high), bubble (wins), load, d bundle in, q bundle out.
module if_id
    import inst_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   bubble,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, next-PC selection and ROM drive for the IF stage.
// Ports: clk, rst, stall, flush/new_pc, branch_flag/branch_target_addr,
// rom (inst_fetch_if.master), id_pc/id_inst/id_valid/id_addr_err to ID.
// Build option: BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction on a
// branch; when undefined the sequential instruction is squashed.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_VECTOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  inst_addr_t          new_pc,
    input  logic                branch_flag,
    input  inst_addr_t          branch_target_addr,
    inst_fetch_if.master        rom,
    output inst_addr_t          id_pc,
    output inst_t               id_inst,
    output logic                id_valid,
    output logic                id_addr_err
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic SQUASH_ON_BRANCH = 1'b0;
`else
    localparam logic SQUASH_ON_BRANCH = 1'b1;
`endif

    logic       ce_q;
    inst_addr_t pc_q;
    inst_addr_t pc_d;
    logic       misal;
    logic       bubble;
    logic       load;
    if_id_t     fetch_d;
    if_id_t     id_q;

    assign misal        = misaligned(pc_q);
    // A misaligned PC must not reach the ROM; the fault rides down IF/ID.
    assign rom.rom_ce   = (ce_q && !misal) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom.rom_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (ce_q) begin
            if (flush) begin
                pc_d = new_pc;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (branch_flag) begin
                pc_d = branch_target_addr;
            end else begin
                pc_d = pc_q + PC_INC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q <= CHIP_DISABLE;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= CHIP_ENABLE;
            pc_q <= pc_d;
        end
    end

    // Flush beats stall; a branch is only seen when not stalled.
    assign bubble = !ce_q || flush
                  || (!stall && branch_flag && SQUASH_ON_BRANCH);
    assign load   = !stall;

    assign fetch_d = '{
        pc:       pc_q,
        inst:     misal ? NOP_INST : rom.rom_inst,
        valid:    1'b1,
        addr_err: misal
    };

    if_id u_if_id (
        .clk    (clk),
        .rst    (rst),
        .bubble (bubble),
        .load   (load),
        .d      (fetch_d),
        .q      (id_q)
    );

    assign id_pc       = id_q.pc;
    assign id_inst     = id_q.inst;
    assign id_valid    = id_q.valid;
    assign id_addr_err = id_q.addr_err;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end of the SammingCPU five-stage pipeline, directly upstream of the instruction ROM. Holds the program counter, drives the ROM chip-enable and address, and captures the ROM's combinational instruction output into the IF/ID pipeline register. Handles stalls, ID-stage branch redirects and exception flushes, and optionally the MIPS branch delay slot.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
- clk  in  1  pipeline clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  from ctrl; holds the PC and IF/ID
- flush  in  1  exception flush from ctrl
- new_pc  in  32  exception handler address, used when flush=1
- branch_flag  in  1  ID stage resolved a taken branch or jump
- branch_target_addr  in  32  target for branch_flag
- rom_ce  out  1  instruction ROM enable (`ChipEnable / `ChipDisable)
- rom_addr  out  32  byte address to ROM; equals the PC register
- rom_inst  in  32  instruction word from ROM, same cycle as rom_addr
- id_pc  out  32  PC of the instruction held in IF/ID
- id_inst  out  32  instruction held in IF/ID
- id_valid  out  1  IF/ID holds a real instruction, not a bubble
- id_addr_err  out  1  the held PC was not word-aligned (AdEL on fetch)

## Operation
- Reset (async, while rst=1): pc=RESET_VECTOR; rom_ce=0; id_pc=0, id_inst=`ZeroWord, id_valid=0, id_addr_err=0.
- rom_ce is a register. It is 0 during reset and 1 from the first rising edge after rst falls. While rom_ce=0, the PC does not advance and IF/ID loads bubbles.
- Next-PC priority, evaluated at each edge with rom_ce=1:
  1. flush: pc<=new_pc.
  2. stall: pc holds.
  3. branch_flag: pc<=branch_target_addr.
  4. Otherwise pc<=pc+4, 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- IF/ID update, same priority:
  - flush: bubble (id_valid=0, id_inst=0, id_addr_err=0, id_pc=0). A simultaneous stall is overridden.
  - stall: all id_* hold.
  - branch_flag: delay-slot behaviour (see Configuration).
  - Otherwise: id_pc<=pc, id_inst<=rom_inst, id_valid<=1, id_addr_err<=(pc[1:0]!=0).
- Misaligned PC (pc[1:0]!=0): rom_ce=0 combinationally for that cycle. IF/ID captures id_inst=0, id_valid=1, id_addr_err=1. The PC still advances, and the exception is resolved by a later flush.
- branch_flag is ignored while stall=1. ID re-presents it when it un-stalls.

## Timing
- Fetch latency: ROM is combinational, so an instruction at pc appears on id_inst one edge after pc is presented.
- Redirect: branch or flush asserted in cycle N → rom_addr = target in cycle N+1 → target instruction in IF/ID in cycle N+2.
- First fetch: RESET_VECTOR on rom_addr with rom_ce=1 in the cycle after the first post-reset edge.
- Reset asserted mid-operation clears everything immediately, independent of clk.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: on branch_flag, the instruction currently at pc (the delay slot) is captured normally into IF/ID and the target follows.
- BRANCH_DELAY_SLOT_EN undefined: on branch_flag, IF/ID loads a bubble, squashing the sequential instruction. The target is fetched with the same timing as the defined case.

## Structure
- Add to defines.v: `ResetVector, `PcInc (32'd4), `NopInst (`ZeroWord). Reuse `InstAddrBus, `InstBus, `ChipEnable/`ChipDisable, `ZeroWord.
- One sub-module: if_id, the IF/ID register with hold/bubble/load controls. inst_fetch contains the PC and next-PC logic and instantiates if_id.

## Test plan
- Reset release with ROM words 0x11,0x22,0x33 at 0,4,8 → rom_ce=0 during reset; then rom_addr 0,4,8 on successive cycles; id_inst 0x11,0x22,0x33 each one cycle later; id_valid=1.
- stall=1 for 2 cycles while pc=8 → rom_addr stays 8; id_inst/id_pc unchanged; sequence resumes at 8 with no lost or duplicated instruction.
- branch_flag with target 0x40 while pc=0x10:
  - defined: id_pc=0x10 (valid), then id_pc=0x40.
  - undefined: bubble, then 0x40.
- flush with new_pc=0x180 during stall=1 and branch_flag=1 → next rom_addr=0x180; id_valid=0 for one cycle.
- branch_target_addr=0x42 → rom_ce=0 for that fetch; id_addr_err=1, id_inst=0, id_pc=0x42, id_valid=1.
- pc=32'hFFFF_FFFC, no events → next rom_addr=0; async rst pulse mid-run → all outputs at reset values before the next edge.
